// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial sensor SPI front end.
// Holds FSM encodings, sensor register addresses and config frames.
package inert_pkg;

  typedef enum logic [3:0] {
    PWRUP,
    CFG0,
    CFG1,
    CFG2,
    CFG3,
    WAIT,
    RD_PL,
    RD_PH,
    RD_AZL,
    RD_AZH,
    LOAD
  } inert_state_t;

  typedef enum logic [2:0] {
    SPI_IDLE,
    SPI_FRONT,
    SPI_SHIFT,
    SPI_BACK,
    SPI_DONE
  } spi_state_t;

  localparam logic [6:0] PITCHL = 7'h22;
  localparam logic [6:0] PITCHH = 7'h23;
  localparam logic [6:0] AZL    = 7'h2C;
  localparam logic [6:0] AZH    = 7'h2D;

  // INT on data ready, accel ODR, gyro ODR, rounding
  localparam logic [15:0] CFG0_FRM = 16'h0D02;
  localparam logic [15:0] CFG1_FRM = 16'h1053;
  localparam logic [15:0] CFG2_FRM = 16'h1150;
  localparam logic [15:0] CFG3_FRM = 16'h1460;

  // Read command: R/W bit set, register address, dummy data byte
  function automatic logic [15:0] rd_frame(input logic [6:0] addr);
    return {1'b1, addr, 8'h00};
  endfunction

endpackage

// File: rtl/inert_intf_spi.sv
// 16-bit SPI master, mode 3, MSB first.
// Owns the SCLK divider and the transmit/receive shift registers.
module spi_mstr16
  import inert_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        done,
  output logic [15:0] rd_data
);

  localparam int HALF = SCLK_DIV / 2;
  localparam int CW   = $clog2(SCLK_DIV);

  spi_state_t    st_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    bit_q;
  logic [15:0]   tx_q;
  logic [15:0]   rx_q;
  logic          ss_q;
  logic          sclk_q;
  logic          mosi_q;
  logic          done_q;

  logic          cnt_wrap;
  logic [CW-1:0] cnt_d;

  assign cnt_wrap = (cnt_q == CW'(SCLK_DIV - 1));
  assign cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;

  // Frame sequencer: SS_n setup, 16 SCLK periods, SS_n hold, done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= SPI_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      ss_q   <= 1'b1;
      sclk_q <= 1'b1;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        SPI_IDLE: begin
          if (wrt) begin
            ss_q  <= 1'b0;
            tx_q  <= cmd;
            cnt_q <= '0;
            bit_q <= '0;
            st_q  <= SPI_FRONT;
          end
        end
        SPI_FRONT: begin
          if (cnt_q == CW'(HALF - 1)) begin
            cnt_q <= '0;
            st_q  <= SPI_SHIFT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SPI_SHIFT: begin
          cnt_q <= cnt_d;
          // falling edge launches the next MOSI bit
          if (cnt_q == '0) begin
            sclk_q <= 1'b0;
            mosi_q <= tx_q[15];
            tx_q   <= {tx_q[14:0], 1'b0};
          end
          // rising edge captures MISO
          if (cnt_q == CW'(HALF)) begin
            sclk_q <= 1'b1;
            rx_q   <= {rx_q[14:0], MISO};
            bit_q  <= bit_q + 5'd1;
            if (bit_q == 5'd15) begin
              cnt_q <= '0;
              st_q  <= SPI_BACK;
            end
          end
        end
        SPI_BACK: begin
          if (cnt_q == CW'(HALF - 1)) begin
            ss_q <= 1'b1;
            st_q <= SPI_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SPI_DONE: begin
          done_q <= 1'b1;
          st_q   <= SPI_IDLE;
        end
        default: st_q <= SPI_IDLE;
      endcase
    end
  end

  assign SS_n    = ss_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign done    = done_q;
  assign rd_data = rx_q;

endmodule

// File: rtl/inert_intf.sv
// Inertial sensor front end: configures the sensor after power-up,
// then reads pitch rate and Z acceleration on each data-ready edge.
module inert_intf
  import inert_pkg::*;
#(
  parameter int SCLK_DIV  = 32,
  parameter int PWRUP_CYC = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ
);

  localparam int TW = (PWRUP_CYC > 2) ? $clog2(PWRUP_CYC) : 1;

  inert_state_t  state_q;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic [2:0]    int_ff_q;
  logic          trig;
  logic          wrt_q;
  logic          issued_q;
  logic [7:0]    pl_q;
  logic [7:0]    ph_q;
  logic [7:0]    azl_q;
  logic [15:0]   ptch_q;
  logic [15:0]   az_q;
  logic          vld_q;

  logic [15:0]   spi_cmd;
  inert_state_t  spi_nxt;
  logic          done;
  logic [15:0]   rd_data;
  logic          unused_hi;

  assign unused_hi = ^rd_data[15:8];
  assign timer_d   = timer_q + 1'b1;
  assign trig      = int_ff_q[1] & ~int_ff_q[2];

  // Two-flop synchroniser plus one delay stage for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) int_ff_q <= '0;
    else     int_ff_q <= {int_ff_q[1:0], INT};
  end

  // Power-up delay counter, frozen once configuration starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  timer_q <= '0;
    else if (state_q == PWRUP) timer_q <= timer_d;
  end

  // Command and successor for each SPI-issuing state
  always_comb begin
    spi_cmd = '0;
    spi_nxt = WAIT;
    unique case (state_q)
      CFG0: begin
        spi_cmd = CFG0_FRM;
        spi_nxt = CFG1;
      end
      CFG1: begin
        spi_cmd = CFG1_FRM;
        spi_nxt = CFG2;
      end
      CFG2: begin
        spi_cmd = CFG2_FRM;
        spi_nxt = CFG3;
      end
      CFG3: begin
        spi_cmd = CFG3_FRM;
        spi_nxt = WAIT;
      end
      RD_PL: begin
        spi_cmd = rd_frame(PITCHL);
        spi_nxt = RD_PH;
      end
      RD_PH: begin
        spi_cmd = rd_frame(PITCHH);
        spi_nxt = RD_AZL;
      end
      RD_AZL: begin
        spi_cmd = rd_frame(AZL);
        spi_nxt = RD_AZH;
      end
      RD_AZH: begin
        spi_cmd = rd_frame(AZH);
        spi_nxt = LOAD;
      end
      default: ;
    endcase
  end

  // Main sequencer; outputs load on the edge entering LOAD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PWRUP;
      wrt_q    <= 1'b0;
      issued_q <= 1'b0;
      pl_q     <= '0;
      ph_q     <= '0;
      azl_q    <= '0;
      ptch_q   <= '0;
      az_q     <= '0;
      vld_q    <= 1'b0;
    end else begin
      wrt_q <= 1'b0;
      vld_q <= 1'b0;
      unique case (state_q)
        PWRUP: begin
          if (timer_q == TW'(PWRUP_CYC - 1)) state_q <= CFG0;
        end
        WAIT: begin
          if (trig) state_q <= RD_PL;
        end
        LOAD: begin
          state_q <= WAIT;
        end
        default: begin
          if (!issued_q) begin
            wrt_q    <= 1'b1;
            issued_q <= 1'b1;
          end else if (done) begin
            issued_q <= 1'b0;
            state_q  <= spi_nxt;
            if (state_q == RD_PL)  pl_q  <= rd_data[7:0];
            if (state_q == RD_PH)  ph_q  <= rd_data[7:0];
            if (state_q == RD_AZL) azl_q <= rd_data[7:0];
            if (state_q == RD_AZH) begin
              ptch_q <= {ph_q, pl_q};
              az_q   <= {rd_data[7:0], azl_q};
              vld_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  spi_mstr16 #(
    .SCLK_DIV(SCLK_DIV)
  ) u_spi (
    .clk    (clk),
    .rst    (rst),
    .wrt    (wrt_q),
    .cmd    (spi_cmd),
    .MISO   (MISO),
    .SS_n   (SS_n),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .done   (done),
    .rd_data(rd_data)
  );

  assign vld     = vld_q;
  assign ptch_rt = ptch_q;
  assign AZ      = az_q;

endmodule
